// File: rtl/i2c_burst_master.sv
// i2c_burst_master: write-only I2C burst master (START, addr+W, ctrl byte, len streamed data bytes, STOP); ports: clk, rst, start/dev_addr/ctrl_byte/len request, data_in/data_valid/data_ready byte stream, busy/done/nack status, scl push-pull, sda open-drain
module i2c_burst_master #(
  parameter int CLK_DIV = 125,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       dev_addr,
  input  logic [7:0]       ctrl_byte,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic             scl,
  inout  tri               sda
);
  localparam int QW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, CTRL, CTRL_ACK, FETCH, DATA, DATA_ACK, STOP, DONE} state_t;
  state_t state, state_n;
  logic [QW-1:0] qcnt;
  logic [1:0] ph;
  logic [2:0] bcnt;
  logic [7:0] sr, ctrl_q;
  logic [LEN_W-1:0] rem;
  logic qend, bend, byte_st, ack_st, sda_oe;
  always_comb begin
    qend = qcnt == QW'(CLK_DIV - 1);
    bend = qend && ph == 2'd3;
    byte_st = state inside {ADDR, CTRL, DATA};
    ack_st = state inside {ADDR_ACK, CTRL_ACK, DATA_ACK};
    data_ready = state == FETCH && data_valid;
    busy = !(state inside {IDLE, DONE});
    done = state == DONE;
    scl = state inside {IDLE, START, DONE} ? 1'b1 : state == FETCH ? 1'b0 : ph[1];
    sda_oe = state inside {START, STOP} || (byte_st && !sr[7]);
  end
  assign sda = sda_oe ? 1'b0 : 1'bz;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = START;
      START:    if (qend && ph == 2'd1) state_n = ADDR;
      ADDR:     if (bend && bcnt == 3'd7) state_n = ADDR_ACK;
      ADDR_ACK: if (bend) state_n = nack ? STOP : CTRL;
      CTRL:     if (bend && bcnt == 3'd7) state_n = CTRL_ACK;
      CTRL_ACK: if (bend) state_n = nack || rem == '0 ? STOP : FETCH;
      FETCH:    if (data_valid) state_n = DATA;
      DATA:     if (bend && bcnt == 3'd7) state_n = DATA_ACK;
      DATA_ACK: if (bend) state_n = nack || rem == '0 ? STOP : FETCH;
      STOP:     if (bend) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt <= '0;
      ph <= '0;
      bcnt <= '0;
      sr <= '0;
      ctrl_q <= '0;
      rem <= '0;
      nack <= 1'b0;
    end else begin
      if (state_n != state) begin
        qcnt <= '0;
        ph <= '0;
        bcnt <= '0;
      end else begin
        qcnt <= qend ? '0 : qcnt + 1'b1;
        if (qend) ph <= ph + 1'b1;
        if (bend) bcnt <= bcnt + 1'b1;
      end
      if (state == IDLE && start) begin
        sr <= {dev_addr, 1'b0};
        ctrl_q <= ctrl_byte;
        rem <= len;
        nack <= 1'b0;
      end
      if (byte_st && bend) sr <= {sr[6:0], 1'b0};
      if (state == ADDR_ACK && bend) sr <= ctrl_q;
      if (data_ready) begin
        sr <= data_in;
        rem <= rem - LEN_W'(rem != '0);
      end
      if (ack_st && ph == 2'd3 && qcnt == '0 && sda) nack <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_burst_master.sv
// tb_i2c_burst_master: bus-event scoreboard bench with an ACKing slave at 0x3C
module tb_i2c_burst_master;
  logic clk = 0, rst = 1, start = 0;
  logic [6:0] dev_addr = 0;
  logic [7:0] ctrl_byte = 0, data_in = 0;
  logic [9:0] len = 0;
  logic data_valid = 0, data_ready, busy, done, nack, scl;
  logic slv_drive = 0;
  wire sda;
  pullup (sda);
  assign sda = slv_drive ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  i2c_burst_master #(.CLK_DIV(4), .LEN_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr), .ctrl_byte(ctrl_byte),
    .len(len), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done), .nack(nack), .scl(scl), .sda(sda)
  );
  typedef struct {
    logic [6:0] addr;
    logic [7:0] ctrl;
    int n;
    bit hold;
    bit exp_nack;
  } vec_t;
  localparam int EV_START = 1000, EV_STOP = 2000;
  int tests = 0, fails = 0;
  int exp_q[$];
  int dr_cnt = 0, done_cnt = 0, n_bytes = 0, idx = 0;
  bit hold = 0, ready_seen = 0;
  logic [7:0] bytes[8];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic log_ev(input int ev);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL bus_event: got %0d expected none", ev);
    end else check("bus_event", ev, exp_q.pop_front());
  endtask
  logic pscl = 1, psda = 1, addr_ok = 0, acking = 0;
  logic [7:0] sh = 0;
  int bc = 0, bidx = 0;
  always @(negedge clk) begin
    if (pscl && scl && psda && !sda) begin
      bc = 0;
      bidx = 0;
      acking = 0;
      slv_drive = 0;
      log_ev(EV_START);
    end else if (pscl && scl && !psda && sda) log_ev(EV_STOP);
    else if (!pscl && scl) begin
      if (bc < 8) begin
        sh = {sh[6:0], sda};
        bc++;
      end else log_ev((sda ? 256 : 0) + int'(sh));
    end else if (pscl && !scl) begin
      if (bc == 8 && !acking) begin
        acking = 1;
        if (bidx == 0) addr_ok = sh == 8'h78;
        slv_drive = addr_ok;
        bidx++;
      end else if (acking) begin
        acking = 0;
        slv_drive = 0;
        bc = 0;
      end
    end
    pscl = scl;
    psda = sda;
  end
  always @(negedge clk) begin
    if (data_ready) begin
      dr_cnt++;
      ready_seen = 1;
    end
    if (done) begin
      done_cnt++;
      check("busy_with_done", busy, 0);
    end
  end
  always @(posedge clk) begin
    #1;
    if (ready_seen) begin
      idx++;
      ready_seen = 0;
    end
    data_in = idx < n_bytes ? bytes[idx] : 8'h00;
    data_valid = idx < n_bytes && !(hold && idx == 1);
  end
  task automatic wait_done(input int want);
    int cyc = 0;
    while (done_cnt < want && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    check("done_seen", done_cnt >= want, 1);
  endtask
  task automatic hold_phase(input int n);
    int cyc = 0, bad = 0;
    while (exp_q.size() > n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    while (scl && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_reached", cyc < 5000, 1);
    repeat (50) begin
      @(negedge clk);
      if (scl || data_ready) bad++;
    end
    check("hold_scl_low", bad, 0);
    check("hold_ready_count", dr_cnt, 1);
    hold = 0;
  endtask
  task automatic kick(input logic [6:0] a, input logic [7:0] c, input int n);
    @(posedge clk);
    #1;
    dev_addr = a;
    ctrl_byte = c;
    len = 10'(n);
    start = 1;
    @(negedge clk);
    check("busy_before_accept", busy, 0);
    @(posedge clk);
    #1;
    start = 0;
    dev_addr = 0;
    ctrl_byte = 8'hFF;
    len = 0;
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    check("nack_cleared", nack, 0);
  endtask
  task automatic run_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) bytes[i] = 8'(8'hAE + i);
    n_bytes = v.n;
    idx = 0;
    hold = v.hold;
    dr_cnt = 0;
    done_cnt = 0;
    exp_q.push_back(EV_START);
    if (v.exp_nack) exp_q.push_back(256 + int'({v.addr, 1'b0}));
    else begin
      exp_q.push_back(int'({v.addr, 1'b0}));
      exp_q.push_back(int'(v.ctrl));
      for (int i = 0; i < v.n; i++) exp_q.push_back(int'(bytes[i]));
    end
    exp_q.push_back(EV_STOP);
    kick(v.addr, v.ctrl, v.n);
    if (v.hold) hold_phase(v.n);
    wait_done(1);
    repeat (20) @(posedge clk);
    check("done_count", done_cnt, 1);
    check("ready_count", dr_cnt, v.exp_nack ? 0 : v.n);
    check("nack_flag", nack, v.exp_nack);
    check("busy_idle", busy, 0);
    check("events_left", exp_q.size(), 0);
    exp_q.delete();
  endtask
  vec_t vt[4];
  initial begin
    vt[0] = '{7'h3C, 8'h00, 2, 1'b0, 1'b0};
    vt[1] = '{7'h3C, 8'h40, 0, 1'b0, 1'b0};
    vt[2] = '{7'h3D, 8'h00, 2, 1'b0, 1'b1};
    vt[3] = '{7'h3C, 8'h40, 3, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) run_vec(vt[i]);
    begin
      int cyc = 0, rises = 0;
      logic p;
      bytes[0] = 8'h55;
      bytes[1] = 8'h55;
      n_bytes = 2;
      idx = 0;
      dr_cnt = 0;
      exp_q.push_back(EV_START);
      exp_q.push_back(32'h78);
      exp_q.push_back(32'h00);
      kick(7'h3C, 8'h00, 2);
      while (dr_cnt == 0 && cyc < 5000) begin
        @(negedge clk);
        cyc++;
      end
      p = scl;
      while (!(rises == 4 && !scl) && cyc < 5000) begin
        @(negedge clk);
        if (!p && scl) rises++;
        p = scl;
        cyc++;
      end
      check("rst_point_reached", cyc < 5000, 1);
      check("mid_byte_sda_low", sda, 0);
      #2 rst = 1;
      #1;
      check("mid_rst_scl", scl, 1);
      check("mid_rst_sda", sda, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", data_ready, 0);
      check("mid_rst_done", done, 0);
      n_bytes = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (10) @(negedge clk);
      check("rst_events_left", exp_q.size(), 0);
      exp_q.delete();
    end
    run_vec(vt[0]);
    n_bytes = 0;
    done_cnt = 0;
    dr_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(EV_START);
      exp_q.push_back(32'h78);
      exp_q.push_back(32'h40);
      exp_q.push_back(EV_STOP);
    end
    @(posedge clk);
    #1;
    dev_addr = 7'h3C;
    ctrl_byte = 8'h40;
    len = 0;
    start = 1;
    wait_done(1);
    check("held_first_events_left", exp_q.size(), 4);
    @(negedge clk);
    check("held_gap_busy", busy, 0);
    @(negedge clk);
    check("held_restart_busy", busy, 1);
    @(posedge clk);
    #1 start = 0;
    wait_done(2);
    repeat (20) @(posedge clk);
    check("held_done_count", done_cnt, 2);
    check("held_events_left", exp_q.size(), 0);
    check("held_ready_count", dr_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule
